// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_ADJ_TH  = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more,
// so the following left shift carries a decimal ten into the next digit.
module bcd_adjust_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // A valid digit is at most 9 here, so din+3 never exceeds 4 bits.
    assign dout = (din >= BCD_ADJ_TH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/decoder_hex_10.sv
// Decimal 7-segment decoder, segments {g,f,e,d,c,b,a}, active-high.
// Codes 10..15 are not decimal digits and blank the display.
module decoder_hex_10 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit-to-segment lookup.
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a registered BCD result and per-digit 7-segment codes.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  err,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int                SR_W  = BCD_DIGIT_W*DIGITS + BIN_W;
    localparam int                CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BIN_W - 1);
    localparam int unsigned       LIMIT = 10**DIGITS;

    state_t                               state, state_nxt;
    logic [SR_W-1:0]                      sr;
    logic [SR_W-1:0]                      sr_adj;
    logic [CNT_W-1:0]                     cnt;
    logic                                 err_n;
    logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   bcd_cur, bcd_adj, bcd_q;
    logic [DIGITS-1:0][6:0]               seg_d;

    // The BCD digits live above the not-yet-shifted binary bits.
    assign bcd_cur = sr[SR_W-1:BIN_W];
    assign sr_adj  = {bcd_adj, sr[BIN_W-1:0]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_adjust_digit u_adj (
            .din  (bcd_cur[g]),
            .dout (bcd_adj[g])
        );
        decoder_hex_10 u_dec (
            .digit (bcd_q[g]),
            .seg   (seg_d[g])
        );
    end

    assign bcd = bcd_q;
    assign seg = seg_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept in IDLE, BIN_W shift cycles, one result cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)       state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == LAST) state_nxt = S_DONE;
            S_DONE:                   state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture, adjust-and-shift, then publish result with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            cnt   <= '0;
            err_n <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            bcd_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    sr    <= {{(BCD_DIGIT_W*DIGITS){1'b0}}, bin};
                    cnt   <= '0;
                    err_n <= (32'(bin) >= LIMIT);
                    busy  <= 1'b1;
                end
                S_SHIFT: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    // busy drops with the last shift so it never overlaps done.
                    if (cnt == LAST) busy <= 1'b0;
                end
                S_DONE: begin
                    bcd_q <= bcd_cur;
                    err   <= err_n;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
